// File: rtl/vga_pkg.sv
// Shared phase type, default 640x480@60 timing and small helpers
// for the VGA scan sequencer (vga_timing_ctrl).
package vga_pkg;

    typedef enum logic [1:0] {
        SYNC,
        BP,
        ACTIVE,
        FP
    } vga_phase_t;

    localparam int VGA_CLK_DIV  = 2;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_FB_W     = 320;

    function automatic int phase_len(
        vga_phase_t phase,
        int         sync,
        int         bp,
        int         act,
        int         fp
    );
        case (phase)
            SYNC:    return sync;
            BP:      return bp;
            ACTIVE:  return act;
            default: return fp;
        endcase
    endfunction

    // FP wraps back to SYNC through the 2-bit encoding.
    function automatic vga_phase_t next_phase(vga_phase_t phase);
        return vga_phase_t'(phase + 2'd1);
    endfunction

    function automatic int cnt_w(int a, int b, int c, int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/vga_axis_seq.sv
// One scan axis: SYNC -> BP -> ACTIVE -> FP phase FSM with a phase
// counter that clears on every phase change; wrap marks FP -> SYNC.
module vga_axis_seq
    import vga_pkg::*;
#(
    parameter int SYNC_LEN = VGA_H_SYNC,
    parameter int BP_LEN   = VGA_H_BP,
    parameter int ACT_LEN  = VGA_H_ACTIVE,
    parameter int FP_LEN   = VGA_H_FP,
    parameter int PW       = cnt_w(SYNC_LEN, BP_LEN, ACT_LEN, FP_LEN)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          step,
    output vga_phase_t    phase,
    output logic [PW-1:0] pos,
    output logic          wrap
);

    vga_phase_t    phase_q;
    vga_phase_t    phase_d;
    logic [PW-1:0] pos_q;
    logic [PW-1:0] pos_d;
    logic          last;

    always_comb begin
        last = (int'(pos_q) ==
                phase_len(phase_q, SYNC_LEN, BP_LEN, ACT_LEN, FP_LEN) - 1);
        phase_d = phase_q;
        pos_d   = pos_q;
        if (step) begin
            if (last) begin
                phase_d = next_phase(phase_q);
                pos_d   = '0;
            end else begin
                pos_d = pos_q + 1'b1;
            end
        end
        wrap = step && (phase_q == FP) && last;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= SYNC;
            pos_q   <= '0;
        end else begin
            phase_q <= phase_d;
            pos_q   <= pos_d;
        end
    end

    assign phase = phase_q;
    assign pos   = pos_q;

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA scan sequencer: pixel-rate divider, H/V phase FSMs, sync/blank,
// coordinates and 2x-upscaled framebuffer address. `VGA_FRAME_CNT_EN adds frame_cnt/frame_odd.
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = VGA_CLK_DIV,
    parameter int H_ACTIVE  = VGA_H_ACTIVE,
    parameter int H_FP      = VGA_H_FP,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BP      = VGA_H_BP,
    parameter int V_ACTIVE  = VGA_V_ACTIVE,
    parameter int V_FP      = VGA_V_FP,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BP      = VGA_V_BP,
    parameter int FB_W      = VGA_FB_W,
    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1,
    localparam int AW = (FB_W * V_ACTIVE / 2 > 1) ?
                        $clog2(FB_W * V_ACTIVE / 2) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    output logic          vga_clk,
    output logic          pix_tick,
    output logic          hsync_n,
    output logic          vsync_n,
    output logic          blank_n,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
`ifdef VGA_FRAME_CNT_EN
    output logic [AW-1:0] fb_addr,
    output logic [15:0]   frame_cnt,
    output logic          frame_odd
`else
    output logic [AW-1:0] fb_addr
`endif
);

    localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HPW = cnt_w(H_SYNC, H_BP, H_ACTIVE, H_FP);
    localparam int VPW = cnt_w(V_SYNC, V_BP, V_ACTIVE, V_FP);

    logic [DW-1:0]  div_q;
    logic [DW-1:0]  div_d;
    logic           div_last;
    logic           run_q;
    logic           tick;
    logic           vga_clk_q;
    logic           vga_clk_d;

    vga_phase_t     h_phase;
    vga_phase_t     h_nphase;
    logic [HPW-1:0] h_pos;
    logic [HPW-1:0] h_npos;
    logic           h_last;
    logic           h_wrap;

    vga_phase_t     v_phase;
    vga_phase_t     v_nphase;
    logic [VPW-1:0] v_pos;
    logic [VPW-1:0] v_npos;
    logic           v_last;
    logic           v_wrap;

    logic           hsync_n_q;
    logic           hsync_n_d;
    logic           vsync_n_q;
    logic           vsync_n_d;
    logic           blank_n_q;
    logic           blank_n_d;
    logic [XW-1:0]  x_q;
    logic [XW-1:0]  x_d;
    logic [YW-1:0]  y_q;
    logic [YW-1:0]  y_d;
    logic [AW-1:0]  fb_addr_q;
    logic [AW-1:0]  fb_addr_d;
    logic           line_start_c;
    logic           frame_start_c;

    // run_q keeps the strobe low while reset is held, even with CLK_DIV=1.
    always_comb begin
        div_last = (int'(div_q) == CLK_DIV - 1);
        tick     = enable && run_q && div_last;
        div_d    = div_q;
        if (enable) begin
            div_d = div_last ? '0 : div_q + 1'b1;
        end
        vga_clk_d = (int'(div_d) >= CLK_DIV / 2);
    end

    vga_axis_seq #(
        .SYNC_LEN (H_SYNC),
        .BP_LEN   (H_BP),
        .ACT_LEN  (H_ACTIVE),
        .FP_LEN   (H_FP),
        .PW       (HPW)
    ) u_h_axis (
        .clk      (clk),
        .reset_n  (reset_n),
        .step     (tick),
        .phase    (h_phase),
        .pos      (h_pos),
        .wrap     (h_wrap)
    );

    vga_axis_seq #(
        .SYNC_LEN (V_SYNC),
        .BP_LEN   (V_BP),
        .ACT_LEN  (V_ACTIVE),
        .FP_LEN   (V_FP),
        .PW       (VPW)
    ) u_v_axis (
        .clk      (clk),
        .reset_n  (reset_n),
        .step     (h_wrap),
        .phase    (v_phase),
        .pos      (v_pos),
        .wrap     (v_wrap)
    );

    // Look-ahead of the axis registers so outputs land with them.
    always_comb begin
        h_last = (int'(h_pos) ==
                  phase_len(h_phase, H_SYNC, H_BP, H_ACTIVE, H_FP) - 1);
        v_last = (int'(v_pos) ==
                  phase_len(v_phase, V_SYNC, V_BP, V_ACTIVE, V_FP) - 1);

        h_nphase = h_phase;
        h_npos   = h_pos;
        if (h_wrap) begin
            h_nphase = SYNC;
            h_npos   = '0;
        end else if (tick) begin
            if (h_last) begin
                h_nphase = next_phase(h_phase);
                h_npos   = '0;
            end else begin
                h_npos = h_pos + 1'b1;
            end
        end

        v_nphase = v_phase;
        v_npos   = v_pos;
        if (v_wrap) begin
            v_nphase = SYNC;
            v_npos   = '0;
        end else if (h_wrap) begin
            if (v_last) begin
                v_nphase = next_phase(v_phase);
                v_npos   = '0;
            end else begin
                v_npos = v_pos + 1'b1;
            end
        end

        line_start_c  = tick && (h_phase == BP) && h_last;
        frame_start_c = line_start_c && (v_phase == ACTIVE) &&
                        (v_pos == '0);

        hsync_n_d = (h_nphase != SYNC);
        vsync_n_d = (v_nphase != SYNC);
        blank_n_d = (h_nphase == ACTIVE) && (v_nphase == ACTIVE);
        x_d       = (h_nphase == ACTIVE) ? h_npos[XW-1:0] : x_q;
        y_d       = (v_nphase == ACTIVE) ? v_npos[YW-1:0] : y_q;

        fb_addr_d = fb_addr_q;
        if (enable) begin
            fb_addr_d = AW'(y_q >> 1) * AW'(FB_W) + AW'(x_q >> 1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q     <= 1'b0;
            div_q     <= '0;
            vga_clk_q <= 1'b0;
            hsync_n_q <= 1'b1;
            vsync_n_q <= 1'b1;
            blank_n_q <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            fb_addr_q <= '0;
        end else begin
            run_q     <= 1'b1;
            div_q     <= div_d;
            vga_clk_q <= vga_clk_d;
            hsync_n_q <= hsync_n_d;
            vsync_n_q <= vsync_n_d;
            blank_n_q <= blank_n_d;
            x_q       <= x_d;
            y_q       <= y_d;
            fb_addr_q <= fb_addr_d;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;
    logic [15:0] frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_start_c) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign frame_odd = frame_cnt_q[0];
`endif

    assign vga_clk     = vga_clk_q;
    assign pix_tick    = tick;
    assign hsync_n     = hsync_n_q;
    assign vsync_n     = vsync_n_q;
    assign blank_n     = blank_n_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_c;
    assign frame_start = frame_start_c;
    assign fb_addr     = fb_addr_q;

endmodule
